// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared fetch-side constants: PC-select encodings, reset vector and fetch FSM states.
// Imported by the redirect controller and its interface.
package fetch_redirect_ctrl_pkg;

    localparam logic [1:0]  PC_SEL_PC4 = 2'b00;
    localparam logic [1:0]  PC_SEL_JAL = 2'b01;
    localparam logic [1:0]  PC_SEL_BRJ = 2'b10;

    localparam logic [31:0] PC_RESET   = 32'h0000_2000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle between the core pipeline (master) and the fetch redirect controller (slave).
// Carries the stall and PC-select inputs and the fetch address / kill outputs.
interface fetch_redirect_ctrl_if;

    logic        pipe_stall_i;
    logic        if_stall_i;
    logic [1:0]  pc_select_i;
    logic [31:0] jal_target_ID_i;
    logic [31:0] br_target_X_i;
    logic [31:0] pc_next_o;
    logic [31:0] pc_IF_o;
    logic        ctrl_kill_ID_o;
    logic        ctrl_kill_X_o;
    logic        redirect_pend_o;

    modport slave (
        input  pipe_stall_i, if_stall_i, pc_select_i, jal_target_ID_i, br_target_X_i,
        output pc_next_o, pc_IF_o, ctrl_kill_ID_o, ctrl_kill_X_o, redirect_pend_o
    );

    modport master (
        output pipe_stall_i, if_stall_i, pc_select_i, jal_target_ID_i, br_target_X_i,
        input  pc_next_o, pc_IF_o, ctrl_kill_ID_o, ctrl_kill_X_o, redirect_pend_o
    );

endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: owns pc_IF, buffers redirects that arrive during an I-cache
// stall, and generates the ID/X kill bits that squash wrong-path instructions.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_redirect_ctrl_if.slave   fr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_if_q, pc_if_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         kill_id_q, kill_id_d;
    logic         kill_x_q, kill_x_d;

    logic         redir_x, redir_j, redir;
    logic [31:0]  tgt;
    logic [31:0]  pc_next;

    // A freeze masks the redirect inputs entirely; X re-presents them afterwards.
    always_comb begin
        redir_x = ~fr.pipe_stall_i & (fr.pc_select_i == PC_SEL_BRJ);
        redir_j = ~fr.pipe_stall_i & (fr.pc_select_i == PC_SEL_JAL) & ~kill_id_q;
        redir   = redir_x | redir_j;
        tgt     = redir_x ? fr.br_target_X_i : fr.jal_target_ID_i;
    end

    always_comb begin
        state_d   = state_q;
        pc_if_d   = pc_if_q;
        pend_pc_d = pend_pc_q;
        kill_id_d = kill_id_q;
        kill_x_d  = kill_x_q;

        if (redir)
            pc_next = tgt;
        else if (state_q == PEND)
            pc_next = pend_pc_q;
        else
            pc_next = pc_if_q + 32'd4;

        if (!fr.pipe_stall_i) begin
            // PEND term squashes the stale-path word returning as the buffered target issues.
            kill_id_d = redir | fr.if_stall_i | (state_q == PEND);
            kill_x_d  = kill_id_q | redir_x;
            if (!fr.if_stall_i) begin
                pc_if_d = pc_next;
                state_d = RUN;
            end else if (redir) begin
                pend_pc_d = tgt;
                state_d   = PEND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_if_q   <= RESET_PC;
            pend_pc_q <= RESET_PC;
            kill_id_q <= 1'b1;
            kill_x_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc_if_q   <= pc_if_d;
            pend_pc_q <= pend_pc_d;
            kill_id_q <= kill_id_d;
            kill_x_q  <= kill_x_d;
        end
    end

    assign fr.pc_next_o       = reset ? RESET_PC : pc_next;
    assign fr.pc_IF_o         = pc_if_q;
    assign fr.ctrl_kill_ID_o  = kill_id_q;
    assign fr.ctrl_kill_X_o   = kill_x_q;
    assign fr.redirect_pend_o = (state_q == PEND);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural fetch model.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_2000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_redirect_ctrl_if fr();

    fetch_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .fr    (fr.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model of the fetch unit's architectural state.
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_kid, m_kx;

    function automatic logic [31:0] model_next();
        bit rx, rj;
        rx = (fr.pc_select_i == 2'd2);
        rj = (fr.pc_select_i == 2'd1) && !m_kid;
        if (reset)  return RST_PC;
        if (rx)     return fr.br_target_X_i;
        if (rj)     return fr.jal_target_ID_i;
        if (m_pend) return m_pend_pc;
        return m_pc + 32'd4;
    endfunction

    // Advance the model by one cycle using the inputs now applied, then clock the DUT.
    task automatic tick();
        bit rx, rj, nk_id, nk_x;
        logic [31:0] nxt;
        if (reset) begin
            m_pc = RST_PC; m_pend = 0; m_kid = 1; m_kx = 1;
        end else if (!fr.pipe_stall_i) begin
            rx    = (fr.pc_select_i == 2'd2);
            rj    = (fr.pc_select_i == 2'd1) && !m_kid;
            nxt   = model_next();
            nk_id = rx | rj | fr.if_stall_i | m_pend;
            nk_x  = m_kid | rx;
            if (!fr.if_stall_i) begin
                m_pc = nxt; m_pend = 0;
            end else if (rx || rj) begin
                m_pend = 1; m_pend_pc = rx ? fr.br_target_X_i : fr.jal_target_ID_i;
            end
            m_kid = nk_id; m_kx = nk_x;
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit ps, input bit is, input logic [1:0] sel,
                         input logic [31:0] jal, input logic [31:0] br);
        fr.pipe_stall_i = ps; fr.if_stall_i = is; fr.pc_select_i = sel;
        fr.jal_target_ID_i = jal; fr.br_target_X_i = br;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (fr.pc_next_o !== RST_PC) $display("FAIL reset_pc_next got %h want %h", fr.pc_next_o, RST_PC); else n_pass++;
        tick();
        n_checks++;
        if ({fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o} !== {RST_PC, 3'b110})
            $display("FAIL reset_state got pc=%h kid=%b kx=%b pend=%b want pc=%h 1 1 0",
                     fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o, RST_PC);
        else n_pass++;
        reset = 0;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        n_checks++;
        if (fr.pc_next_o !== 32'h2004 || fr.ctrl_kill_ID_o !== 1'b1 || fr.ctrl_kill_X_o !== 1'b1)
            $display("FAIL seq_c0 got next=%h kid=%b kx=%b want 2004 1 1", fr.pc_next_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o);
        else n_pass++;
        tick();
        n_checks++;
        if (fr.pc_next_o !== 32'h2008 || fr.pc_IF_o !== 32'h2004)
            $display("FAIL seq_c1 got next=%h pc=%h want 2008 2004", fr.pc_next_o, fr.pc_IF_o);
        else n_pass++;
        tick();
        n_checks++;
        if (fr.ctrl_kill_ID_o !== 1'b0 || fr.ctrl_kill_X_o !== 1'b0)
            $display("FAIL seq_kills_c2 got kid=%b kx=%b want 0 0", fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o);
        else n_pass++;
    endtask

    task automatic test_redirect_x();
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        tick();
        tick();
        n_checks++;
        if (fr.pc_IF_o !== 32'h2010) $display("FAIL brx_setup got pc=%h want 2010", fr.pc_IF_o); else n_pass++;
        drive(0, 0, 2'd2, 32'h0, 32'h3000);
        n_checks++;
        if (fr.pc_next_o !== 32'h3000) $display("FAIL brx_same_cycle got %h want 3000", fr.pc_next_o); else n_pass++;
        tick();
        n_checks++;
        if ({fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o} !== {32'h3000, 2'b11})
            $display("FAIL brx_next got pc=%h kid=%b kx=%b want 3000 1 1", fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o);
        else n_pass++;
    endtask

    task automatic test_killed_jal();
        drive(0, 0, 2'd1, 32'h7000, 32'h0);
        n_checks++;
        if (fr.pc_next_o !== 32'h3004) $display("FAIL killed_jal got %h want 3004", fr.pc_next_o); else n_pass++;
        tick();
        n_checks++;
        if (fr.pc_IF_o !== 32'h3004 || fr.ctrl_kill_ID_o !== 1'b0)
            $display("FAIL killed_jal_after got pc=%h kid=%b want 3004 0", fr.pc_IF_o, fr.ctrl_kill_ID_o);
        else n_pass++;
    endtask

    task automatic test_pend_jal();
        drive(0, 1, 2'd1, 32'h2400, 32'h0);
        tick();
        n_checks++;
        if (fr.redirect_pend_o !== 1'b1 || fr.pc_IF_o !== 32'h3004)
            $display("FAIL pend_rise got pend=%b pc=%h want 1 3004", fr.redirect_pend_o, fr.pc_IF_o);
        else n_pass++;
        drive(0, 1, 2'd0, 32'h0, 32'h0);
        tick();
        tick();
        n_checks++;
        if (fr.redirect_pend_o !== 1'b1) $display("FAIL pend_hold got %b want 1", fr.redirect_pend_o); else n_pass++;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        n_checks++;
        if (fr.pc_next_o !== 32'h2400 || fr.ctrl_kill_ID_o !== 1'b1)
            $display("FAIL pend_issue got next=%h kid=%b want 2400 1", fr.pc_next_o, fr.ctrl_kill_ID_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({fr.pc_IF_o, fr.redirect_pend_o, fr.ctrl_kill_ID_o} !== {32'h2400, 2'b01})
            $display("FAIL pend_drop got pc=%h pend=%b kid=%b want 2400 0 1", fr.pc_IF_o, fr.redirect_pend_o, fr.ctrl_kill_ID_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_pipe_stall();
        logic [31:0] pc0;
        bit kid0, kx0;
        pc0 = m_pc; kid0 = m_kid; kx0 = m_kx;
        drive(1, 1, 2'd2, 32'h0, 32'h3800);
        tick();
        tick();
        n_checks++;
        if ({fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o} !== {pc0, kid0, kx0, 1'b0})
            $display("FAIL freeze_hold got pc=%h kid=%b kx=%b pend=%b want %h %b %b 0",
                     fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o, pc0, kid0, kx0);
        else n_pass++;
        drive(0, 0, 2'd2, 32'h0, 32'h3800);
        n_checks++;
        if (fr.pc_next_o !== 32'h3800) $display("FAIL freeze_release got %h want 3800", fr.pc_next_o); else n_pass++;
        tick();
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if (fr.pc_IF_o !== 32'h3804 || fr.ctrl_kill_ID_o !== 1'b0)
            $display("FAIL freeze_once got pc=%h kid=%b want 3804 0", fr.pc_IF_o, fr.ctrl_kill_ID_o);
        else n_pass++;
    endtask

    task automatic test_reset_pend();
        drive(0, 1, 2'd2, 32'h0, 32'h5000);
        tick();
        n_checks++;
        if (fr.redirect_pend_o !== 1'b1) $display("FAIL brx_ifstall_pend got %b want 1", fr.redirect_pend_o); else n_pass++;
        reset = 1;
        drive(0, 1, 2'd0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if ({fr.pc_IF_o, fr.redirect_pend_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o} !== {RST_PC, 3'b011})
            $display("FAIL reset_pend got pc=%h pend=%b kid=%b kx=%b want 2000 0 1 1",
                     fr.pc_IF_o, fr.redirect_pend_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o);
        else n_pass++;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'd0, 32'h0, 32'h0);
            n_checks++;
            if (fr.pc_next_o === 32'h5000 || fr.pc_next_o !== RST_PC + 32'd4 * (i + 1))
                $display("FAIL reset_pend_discard got %h want %h", fr.pc_next_o, RST_PC + 32'd4 * (i + 1));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30, 2'($urandom_range(0, 3)),
                  $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
            exp_next = model_next();
            if (reset || !fr.pipe_stall_i) begin
                n_checks++;
                if (fr.pc_next_o !== exp_next) $display("FAIL rnd_next cyc %0d got %h want %h", i, fr.pc_next_o, exp_next);
                else n_pass++;
            end
            tick();
            n_checks++;
            if ({fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o} !== {m_pc, m_kid, m_kx, m_pend})
                $display("FAIL rnd_state cyc %0d got pc=%h kid=%b kx=%b pend=%b want %h %b %b %b", i,
                         fr.pc_IF_o, fr.ctrl_kill_ID_o, fr.ctrl_kill_X_o, fr.redirect_pend_o, m_pc, m_kid, m_kx, m_pend);
            else n_pass++;
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        fr.pipe_stall_i = 0; fr.if_stall_i = 0; fr.pc_select_i = 2'd0;
        fr.jal_target_ID_i = 32'h0; fr.br_target_X_i = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_redirect_x();
        test_killed_jal();
        test_pend_jal();
        test_pipe_stall();
        test_reset_pend();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
